path_metric_unit: RTL and testbench

- Path Metric Unit (PMU) of the 4-state (K=3) Viterbi decoder.
- Holds the current path metric of each trellis state in a register bank. Each bank entry is loaded from the ACS (add-compare-select) outputs when a step is valid.
- Feeds the registered metrics back to the ACS stage and to traceback.
- Also reports the best (minimum-metric) state for traceback start.

---
 rtl/viterbi_pkg.sv | 10 +
 rtl/path_metric_unit_if.sv | 29 ++
 rtl/path_metric_unit_pm_min4.sv | 36 +++
 rtl/path_metric_unit.sv | 80 ++++++++
 tb/tb_path_metric_unit.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and constants for the 4-state (K=3) Viterbi decoder.
package viterbi_pkg;
  localparam int PM_W       = 8;
  localparam int NUM_STATES = 4;

  typedef logic [PM_W-1:0] pm_t;
  typedef logic [1:0]      state_idx_t;

  localparam pm_t PM_INIT_MAX = '1;
endpackage

// File: rtl/path_metric_unit_if.sv
// Metric bus between ACS, path metric unit and traceback.
interface path_metric_unit_if
  import viterbi_pkg::*;
  ;
  logic       valid_i;
  pm_t        pm_new_s0_i;
  pm_t        pm_new_s1_i;
  pm_t        pm_new_s2_i;
  pm_t        pm_new_s3_i;
  pm_t        pm_current_s0_o;
  pm_t        pm_current_s1_o;
  pm_t        pm_current_s2_o;
  pm_t        pm_current_s3_o;
  state_idx_t best_state_o;
  pm_t        best_pm_o;
  logic       valid_o;

  modport master (
    output valid_i, pm_new_s0_i, pm_new_s1_i, pm_new_s2_i, pm_new_s3_i,
    input  pm_current_s0_o, pm_current_s1_o, pm_current_s2_o, pm_current_s3_o,
    input  best_state_o, best_pm_o, valid_o
  );

  modport slave (
    input  valid_i, pm_new_s0_i, pm_new_s1_i, pm_new_s2_i, pm_new_s3_i,
    output pm_current_s0_o, pm_current_s1_o, pm_current_s2_o, pm_current_s3_o,
    output best_state_o, best_pm_o, valid_o
  );
endinterface

// File: rtl/path_metric_unit_pm_min4.sv
// Unsigned minimum of four metrics with its index; ties go to the lowest index.
module pm_min4
  import viterbi_pkg::*;
(
  input  pm_t        a0,
  input  pm_t        a1,
  input  pm_t        a2,
  input  pm_t        a3,
  output pm_t        min_val,
  output state_idx_t min_idx
);
  pm_t        lo_val, hi_val;
  state_idx_t lo_idx, hi_idx;

  // Strict less-than at every node keeps the lower index on ties.
  always_comb begin
    lo_val = a0;
    lo_idx = 2'd0;
    if (a1 < a0) begin
      lo_val = a1;
      lo_idx = 2'd1;
    end
    hi_val = a2;
    hi_idx = 2'd2;
    if (a3 < a2) begin
      hi_val = a3;
      hi_idx = 2'd3;
    end
    min_val = lo_val;
    min_idx = lo_idx;
    if (hi_val < lo_val) begin
      min_val = hi_val;
      min_idx = hi_idx;
    end
  end
endmodule

// File: rtl/path_metric_unit.sv
// Path metric register bank with best-state search.
// Define PMU_NORM_EN to subtract the input minimum from every metric on load.
module path_metric_unit
  import viterbi_pkg::*;
(
  input logic               clk,
  input logic               rst,
  path_metric_unit_if.slave bus
);
  pm_t  pm_new  [NUM_STATES];
  pm_t  pm_load [NUM_STATES];
  pm_t  pm_q    [NUM_STATES];
  logic valid_q;

  assign pm_new[0] = bus.pm_new_s0_i;
  assign pm_new[1] = bus.pm_new_s1_i;
  assign pm_new[2] = bus.pm_new_s2_i;
  assign pm_new[3] = bus.pm_new_s3_i;

`ifdef PMU_NORM_EN
  pm_t        in_min;
  state_idx_t in_min_idx;

  pm_min4 u_in_min (
    .a0      (pm_new[0]),
    .a1      (pm_new[1]),
    .a2      (pm_new[2]),
    .a3      (pm_new[3]),
    .min_val (in_min),
    .min_idx (in_min_idx)
  );

  // Subtraction never underflows because in_min is the smallest input.
  always_comb begin
    for (int k = 0; k < NUM_STATES; k++) begin
      pm_load[k] = pm_new[k] - in_min;
    end
    pm_load[in_min_idx] = '0;
  end
`else
  always_comb begin
    for (int k = 0; k < NUM_STATES; k++) begin
      pm_load[k] = pm_new[k];
    end
  end
`endif

  // State 0 starts at zero cost, the others at the maximum metric.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pm_q[0] <= '0;
      pm_q[1] <= PM_INIT_MAX;
      pm_q[2] <= PM_INIT_MAX;
      pm_q[3] <= PM_INIT_MAX;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.valid_i;
      if (bus.valid_i) begin
        for (int k = 0; k < NUM_STATES; k++) begin
          pm_q[k] <= pm_load[k];
        end
      end
    end
  end

  pm_min4 u_best (
    .a0      (pm_q[0]),
    .a1      (pm_q[1]),
    .a2      (pm_q[2]),
    .a3      (pm_q[3]),
    .min_val (bus.best_pm_o),
    .min_idx (bus.best_state_o)
  );

  assign bus.pm_current_s0_o = pm_q[0];
  assign bus.pm_current_s1_o = pm_q[1];
  assign bus.pm_current_s2_o = pm_q[2];
  assign bus.pm_current_s3_o = pm_q[3];
  assign bus.valid_o         = valid_q;
endmodule

// File: tb/tb_path_metric_unit.sv
// Scoreboard bench for path_metric_unit against a behavioural metric model.
module tb_path_metric_unit;
  import viterbi_pkg::*;

  logic clk;
  logic rst;

  path_metric_unit_if bus ();

  path_metric_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pm [4];
    int bs;
    int bp;
    int v;
  } exp_t;

  exp_t sb [$];
  int   total = 0;
  int   bad   = 0;
  int   model_pm [4];

  task automatic check(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic exp_t model_view(input int v);
    exp_t e;
    e.bs = 0;
    e.bp = model_pm[0];
    for (int i = 0; i < 4; i++) begin
      e.pm[i] = model_pm[i];
      if (model_pm[i] < e.bp) begin
        e.bp = model_pm[i];
        e.bs = i;
      end
    end
    e.v = v;
    return e;
  endfunction

  task automatic model_reset();
    model_pm[0] = 0;
    for (int i = 1; i < 4; i++) model_pm[i] = 255;
  endtask

  task automatic check_now(input exp_t e);
    check("pm0", int'(bus.pm_current_s0_o), e.pm[0]);
    check("pm1", int'(bus.pm_current_s1_o), e.pm[1]);
    check("pm2", int'(bus.pm_current_s2_o), e.pm[2]);
    check("pm3", int'(bus.pm_current_s3_o), e.pm[3]);
    check("best_state", int'(bus.best_state_o), e.bs);
    check("best_pm", int'(bus.best_pm_o), e.bp);
    check("valid_o", int'(bus.valid_o), e.v);
  endtask

  // Drive one step before the next edge and queue what that edge must produce.
  task automatic step(input logic v, input int a0, input int a1, input int a2, input int a3);
    int in [4];
    int mn;
    @(negedge clk);
    bus.valid_i     = v;
    bus.pm_new_s0_i = pm_t'(a0);
    bus.pm_new_s1_i = pm_t'(a1);
    bus.pm_new_s2_i = pm_t'(a2);
    bus.pm_new_s3_i = pm_t'(a3);
    if (v) begin
      in[0] = a0; in[1] = a1; in[2] = a2; in[3] = a3;
      mn = in[0];
      foreach (in[i]) if (in[i] < mn) mn = in[i];
`ifdef PMU_NORM_EN
      foreach (in[i]) model_pm[i] = in[i] - mn;
`else
      foreach (in[i]) model_pm[i] = in[i];
`endif
    end
    sb.push_back(model_view(int'(v)));
  endtask

  // Monitor: one expected record per clock edge while stimulus is active.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_now(e);
      end
    end
  end

  initial begin
    rst             = 1'b1;
    bus.valid_i     = 1'b0;
    bus.pm_new_s0_i = '0;
    bus.pm_new_s1_i = '0;
    bus.pm_new_s2_i = '0;
    bus.pm_new_s3_i = '0;
    model_reset();
    #9;
    check_now(model_view(0));
    #3 rst = 1'b0;

    for (int j = 1; j <= 5; j++) step(1'b1, 10*j, 20*j, 30*j, 40*j);
    for (int j = 0; j < 5; j++) step(1'b0, 255, $urandom_range(0, 255), 7, 0);

    step(1'b1, 0, 0, 0, 0);
    step(1'b1, 40, 12, 12, 200);
    step(1'b1, 9, 9, 9, 9);
    step(1'b1, 30, 30, 5, 5);

    for (int j = 0; j < 20; j++)
      step(1'b1, $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 255));
    for (int j = 0; j < 10; j++)
      step(1'(j % 2 == 0), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 3));

    // Async reset between edges; the queue is drained by the time it lands.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("sb_empty_at_reset", sb.size(), 0);
    check_now(model_view(0));
    #1 rst = 1'b0;
    step(1'b1, 77, 3, 140, 3);
    step(1'b0, 1, 1, 1, 1);

    for (int c = 0; c < 20 && sb.size() > 0; c++) @(posedge clk);
    #2;
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
